// File: rtl/prm_collect_pkg.sv
// Shared types and sizing helpers for the PRM edge-mask collector.
package prm_collect_pkg;

    typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN} state_e;

    localparam int CODE_W_DEF = 15;

    function automatic int num_words(input int n_edges, input int out_w);
        return (n_edges + out_w - 1) / out_w;
    endfunction

endpackage

// File: rtl/prm_mask_word_mux.sv
// Selects one OUT_W-bit word of the collision bitmap, zero-padding past NUM_EDGES.
module prm_mask_word_mux #(
    parameter int NUM_EDGES = 1024,
    parameter int OUT_W     = 32,
    parameter int NUM_WORDS = 32,
    parameter int IDX_W     = 5
) (
    input  logic [NUM_EDGES-1:0] bitmap_i,
    input  logic [IDX_W-1:0]     idx_i,
    output logic [OUT_W-1:0]     word_o
);

    logic [NUM_WORDS*OUT_W-1:0] padded;
    logic [OUT_W-1:0]           words [NUM_WORDS];

    always_comb begin
        padded                  = '0;
        padded[NUM_EDGES-1:0]   = bitmap_i;
        for (int w = 0; w < NUM_WORDS; w++) begin
            words[w] = padded[w*OUT_W +: OUT_W];
        end
    end

    assign word_o = words[idx_i];

endmodule

// File: rtl/prm_edge_mask_collect.sv
// Collects checker-bank edge masks into a sticky per-frame bitmap and drains it word by word.
// Optional hit counter output hit_cnt is enabled by defining PRM_HIT_CNT_EN.
module prm_edge_mask_collect
    import prm_collect_pkg::*;
#(
    parameter  int NUM_EDGES = 1024,
    parameter  int OUT_W     = 32,
    parameter  int CODE_W    = CODE_W_DEF,
    localparam int NUM_WORDS = num_words(NUM_EDGES, OUT_W),
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 obs_valid,
    output logic                 obs_ready,
    input  logic [CODE_W-1:0]    obs_code,
    input  logic                 obs_last,
    output logic [CODE_W-1:0]    chk_code,
    input  logic [NUM_EDGES-1:0] chk_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic [IDX_W-1:0]     out_idx,
    output logic                 out_last,
`ifdef PRM_HIT_CNT_EN
    output logic [15:0]          hit_cnt,
`endif
    output logic                 busy
);

    state_e                 state_q, state_d;
    logic [NUM_EDGES-1:0]   bitmap_q, bitmap_d;
    logic [CODE_W-1:0]      chk_code_q, chk_code_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   busy_q, busy_d;
    logic                   accept, last_hs;

    assign obs_ready = (state_q == ACCUM);
    assign out_valid = (state_q == DRAIN);
    assign out_last  = out_valid && (idx_q == IDX_W'(NUM_WORDS - 1));
    assign accept    = obs_valid && obs_ready;
    assign last_hs   = out_last && out_ready;

    // NOTE: every variable is given a default before the case, so no latches are inferred.
    always_comb begin
        state_d    = state_q;
        bitmap_d   = bitmap_q;
        chk_code_d = accept ? obs_code : chk_code_q;
        s1_valid_d = accept;
        idx_d      = idx_q;
        busy_d     = busy_q | accept;
        if (s1_valid_q) begin
            bitmap_d = bitmap_q | chk_mask;
        end
        case (state_q)
            ACCUM: if (accept && obs_last) state_d = FLUSH;
            FLUSH: begin
                state_d = DRAIN;
                idx_d   = '0;
            end
            DRAIN: begin
                if (out_ready) idx_d = idx_q + IDX_W'(1);
                if (last_hs) begin
                    state_d  = ACCUM;
                    bitmap_d = '0;
                    idx_d    = '0;
                    busy_d   = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    // NOTE: the bitmap is frame state, not a RAM, so it is reset with everything else;
    // sequential state is only ever assigned with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            bitmap_q   <= '0;
            chk_code_q <= '0;
            s1_valid_q <= 1'b0;
            idx_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitmap_q   <= bitmap_d;
            chk_code_q <= chk_code_d;
            s1_valid_q <= s1_valid_d;
            idx_q      <= idx_d;
            busy_q     <= busy_d;
        end
    end

    assign chk_code = chk_code_q;
    assign out_idx  = idx_q;
    assign busy     = busy_q;

    prm_mask_word_mux #(
        .NUM_EDGES (NUM_EDGES),
        .OUT_W     (OUT_W),
        .NUM_WORDS (NUM_WORDS),
        .IDX_W     (IDX_W)
    ) u_word_mux (
        .bitmap_i (bitmap_q),
        .idx_i    (idx_q),
        .word_o   (out_data)
    );

`ifdef PRM_HIT_CNT_EN
    logic [15:0] cnt_q, cnt_d, hit_q, hit_d;

    always_comb begin
        cnt_d = cnt_q;
        hit_d = hit_q;
        if (s1_valid_q && (|chk_mask) && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
        // Latch includes the final code, whose mask lands on this same edge.
        if (state_q == FLUSH) hit_d = cnt_d;
        if (last_hs) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            hit_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            hit_q <= hit_d;
        end
    end

    assign hit_cnt = hit_q;
`endif

endmodule

// File: tb/tb_prm_edge_mask_collect.sv
// Directed self-checking bench for prm_edge_mask_collect with a stub checker bank.
// Hit-counter checks are compiled in when PRM_HIT_CNT_EN is defined.
module tb_prm_edge_mask_collect;

    localparam int NUM_EDGES = 1024;
    localparam int OUT_W     = 32;
    localparam int CODE_W    = 15;
    localparam int NWORDS    = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 obs_valid;
    logic                 obs_ready;
    logic [CODE_W-1:0]    obs_code;
    logic                 obs_last;
    logic [CODE_W-1:0]    chk_code;
    logic [NUM_EDGES-1:0] chk_mask;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_W-1:0]     out_data;
    logic [4:0]           out_idx;
    logic                 out_last;
    logic                 busy;
`ifdef PRM_HIT_CNT_EN
    logic [15:0]          hit_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    logic [OUT_W-1:0] exp_words [NWORDS];

    always #5 clk = ~clk;

    // Stub bank: code bit 0 blocks edge 3, bit 1 blocks edge 40, bit 2 blocks nothing.
    always_comb begin
        chk_mask     = '0;
        chk_mask[3]  = chk_code[0];
        chk_mask[40] = chk_code[1];
    end

    prm_edge_mask_collect #(
        .NUM_EDGES (NUM_EDGES),
        .OUT_W     (OUT_W),
        .CODE_W    (CODE_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .obs_valid (obs_valid),
        .obs_ready (obs_ready),
        .obs_code  (obs_code),
        .obs_last  (obs_last),
        .chk_code  (chk_code),
        .chk_mask  (chk_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
`ifdef PRM_HIT_CNT_EN
        .hit_cnt   (hit_cnt),
`endif
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic set_exp(input logic [31:0] w0, input logic [31:0] w1);
        for (int i = 0; i < NWORDS; i++) exp_words[i] = '0;
        exp_words[0] = w0;
        exp_words[1] = w1;
    endtask

    // Called at a negedge; drives one beat, returns at the next negedge.
    task automatic send_code(input logic [CODE_W-1:0] code, input logic last);
        check("obs_ready_before_send", 64'(obs_ready), 64'd1);
        obs_valid = 1'b1;
        obs_code  = code;
        obs_last  = last;
        @(negedge clk);
        obs_valid = 1'b0;
        obs_last  = 1'b0;
    endtask

    // Drains one frame against exp_words; returns at the negedge after the final handshake.
    task automatic drain(input bit stall);
        int  cyc = 0;
        int  exp_idx = 0;
        int  hs = 0;
        bit  done = 0;
        while (!done && cyc < 300) begin
            out_ready = stall ? ((cyc % 2) == 0) : 1'b1;
            if (out_valid) begin
                check("out_idx",  64'(out_idx),  64'(exp_idx));
                check("out_data", 64'(out_data), 64'(exp_words[exp_idx]));
                check("out_last", 64'(out_last), 64'(exp_idx == NWORDS - 1));
                check("busy_in_drain", 64'(busy), 64'd1);
                if (out_ready) begin
                    hs++;
                    if (exp_idx == NWORDS - 1) done = 1;
                    exp_idx++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check("drain_completed", 64'(done), 64'd1);
        check("handshakes", 64'(hs), 64'(NWORDS));
        check("busy_after_drain", 64'(busy), 64'd0);
        check("out_valid_after_drain", 64'(out_valid), 64'd0);
        check("obs_ready_after_drain", 64'(obs_ready), 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        obs_valid = 1'b0;
        obs_code  = '0;
        obs_last  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_obs_ready", 64'(obs_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_idx",   64'(out_idx),   64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_chk_code",  64'(chk_code),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three-code frame, out_ready held high.
        send_code(15'h0001, 1'b0);
        check("busy_after_accept", 64'(busy), 64'd1);
        check("chk_code_reg", 64'(chk_code), 64'h1);
        send_code(15'h0002, 1'b0);
        send_code(15'h0004, 1'b1);
        check("obs_ready_in_flush", 64'(obs_ready), 64'd0);
        set_exp(32'h0000_0008, 32'h0000_0100);
        drain(1'b0);
`ifdef PRM_HIT_CNT_EN
        check("hit_cnt_two", 64'(hit_cnt), 64'd2);
`endif

        // Same frame with out_ready toggling.
        send_code(15'h0001, 1'b0);
        send_code(15'h0002, 1'b0);
        send_code(15'h0004, 1'b1);
        drain(1'b1);

        // Repeated code: sticky OR only.
        for (int i = 0; i < 5; i++) send_code(15'h0001, i == 4);
        set_exp(32'h0000_0008, 32'h0000_0000);
        drain(1'b0);

        // Back-to-back: next frame starts right after the final handshake.
        send_code(15'h0001, 1'b1);
        drain(1'b0);
        send_code(15'h0002, 1'b1);
        set_exp(32'h0000_0000, 32'h0000_0100);
        drain(1'b0);

        // Reset in the middle of a drain.
        send_code(15'h0001, 1'b1);
        begin
            int cyc = 0;
            out_ready = 1'b1;
            while (!(out_valid && out_idx == 5'd5) && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            check("reached_idx5", 64'(out_idx), 64'd5);
            rst_n = 1'b0;
            @(negedge clk);
            out_ready = 1'b0;
            check("midrst_out_valid", 64'(out_valid), 64'd0);
            check("midrst_obs_ready", 64'(obs_ready), 64'd1);
            check("midrst_busy",      64'(busy),      64'd0);
            check("midrst_out_idx",   64'(out_idx),   64'd0);
            check("midrst_out_data",  64'(out_data),  64'd0);
            rst_n = 1'b1;
            @(negedge clk);
        end
        send_code(15'h0002, 1'b1);
        set_exp(32'h0000_0000, 32'h0000_0100);
        drain(1'b0);

`ifdef PRM_HIT_CNT_EN
        // Saturation: 70000 hitting codes in one frame.
        obs_valid = 1'b1;
        obs_code  = 15'h0001;
        for (int i = 0; i < 70000; i++) begin
            obs_last = (i == 69999);
            @(negedge clk);
        end
        obs_valid = 1'b0;
        obs_last  = 1'b0;
        set_exp(32'h0000_0008, 32'h0000_0000);
        drain(1'b0);
        check("hit_cnt_sat", 64'(hit_cnt), 64'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
